crc_hash_pipeline: RTL and testbench
====================================

// Module: crc_hash_pipeline
// PURPOSE
//  Pipelined hash-code generator: a chain of p_len registered CRC stages.
//  Every stage folds the same input word into a running CRC.
//  The output is the CRC of p_len back-to-back copies of the input word
//  sampled p_len cycles earlier.
//  p_PROTECTED=1 gives the radiation-hardened (TMR) variant; it is
//  cycle-for-cycle identical in function to p_PROTECTED=0.
// PARAMETERS
//  p_len           128    number of pipeline stages (>=1); also the latency in cycles
//  p_width         8      CRC/hash width in bits
//  p_polynom       8'h31  generator polynomial, implicit x^p_width term omitted
//  p_inp_data_len  8      input word width in bits (independent of p_width)
//  p_FPGA_CELL_big 1      1: stage regs carry keep/no-SRL attributes; 0: SRL inference allowed; no functional effect
//  p_PROTECTED     0      0: plain chain; 1: triple-modular-redundant chain with per-stage voting
// PORTS
//  clk        input   1               single clock, all logic on rising edge
//  rstN       input   1               synchronous, active-HIGH reset (1 = reset); name kept for codebase compatibility
//  inp_data   input   p_inp_data_len  word to hash, sampled every cycle
//  outp_data  output  p_width         hash of last stage (registered)
// BEHAVIOUR
//  Reset
//   - Reset is synchronous and active-high, one clock, on clk.
//   - While rstN=1 at a clk edge, all stage registers r[*] and data registers d[*] load 0.
//   - In the TMR variant, all three copies of r[*] and d[*] also load 0.
//   - outp_data reads 0 from the first edge with rstN=1.
//   - Reset mid-operation discards all in-flight state; no partial results.
//  crc_update(c, w)
//   - Non-reflected, MSB-first; init 0, no final XOR.
//   - For i = p_inp_data_len-1 down to 0:
//       fb = c[p_width-1] ^ w[i];  c = c<<1 (truncated to p_width);  if fb, c ^= p_polynom.
//   - Purely combinational within the stage.
//  Stage recurrence (each edge, rstN=0)
//   - d[0] <= inp_data;  r[0] <= crc_update(0, inp_data).
//   - For 1 <= i < p_len:  d[i] <= d[i-1];  r[i] <= crc_update(r[i-1], d[i-1]).
//   - outp_data = r[p_len-1]. No ready/valid; a new word is accepted every cycle.
//  Latency and fill
//   - A word present at edge N appears on outp_data after edge N+p_len-1, i.e. a p_len-register delay.
//   - crc_update(0,0) = 0, so after reset outp_data stays 0 until the first input's wave reaches the last stage.
//   - Changing inp_data gives one new hash per cycle; results never mix words.
//  TMR variant (p_PROTECTED=1)
//   - Three copies A/B/C of every r[i] and d[i].
//   - After each stage, a bitwise 2-of-3 majority vote of A/B/C feeds all three copies of stage i+1.
//   - outp_data = majority of the three last-stage copies.
//   - A single-copy upset in any register never reaches outp_data and is scrubbed within one cycle.
//   - Voters must not be optimized away (keep attributes).
//  Width rules
//   - p_inp_data_len and p_width may differ.
//   - The CRC state is always p_width bits; the input is consumed fully, MSB first.
// TESTING
//  1. p_len=128, p_width=8, poly 8'h31, inp_data=8'h30:
//     rstN=1 for 10 cycles, then 0 -> outp_data=0 for 127 edges after release, then constant.
//     Plain and TMR instances must be equal on every cycle.
//  2. p_len=1, inp_data=8'h30 -> outp_data=8'hC5 one cycle after release.
//     p_len=2 -> 8'h77 two cycles after release; inp_data=8'h00 -> 8'h00 always.
//  3. p_len=4, change inp_data each cycle (8'h30, 8'h00, 8'hFF, ...) -> outputs equal a
//     model running crc_update 4x per word, each delayed exactly 4 cycles, no mixing.
//  4. Assert rstN mid-stream for 1 cycle -> outp_data=0 on the next edge.
//     The pipeline refills from zero with latency p_len.
//  5. p_PROTECTED=1: deposit a single-bit flip into copy B of an arbitrary stage r[i] or d[i]
//     -> outp_data unchanged vs. plain instance.
//     Repeat for copy A of the last stage.
//  6. p_width=16, poly 16'h1021, p_inp_data_len=8, p_len=1, inp_data=8'h31
//     -> outp_data=16'h2672 (CRC-16/XMODEM of 0x31).

Source files
------------

// File: rtl/crc_hash_pipeline.sv
// crc_hash_pipeline: p_len-stage registered CRC chain hashing each input word p_len times, optional TMR
module crc_hash_pipeline #(
  parameter int p_len = 128,
  parameter int p_width = 8,
  parameter logic [p_width-1:0] p_polynom = 8'h31,
  parameter int p_inp_data_len = 8,
  parameter bit p_FPGA_CELL_big = 1,
  parameter bit p_PROTECTED = 0
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic [p_inp_data_len-1:0] inp_data,
  output logic [p_width-1:0]        outp_data
);
  function automatic logic [p_width-1:0] crc_update(input logic [p_width-1:0] c, input logic [p_inp_data_len-1:0] w);
    logic [p_width-1:0] x;
    logic fb;
    x = c;
    for (int i = p_inp_data_len - 1; i >= 0; i--) begin
      fb = x[p_width-1] ^ w[i];
      x = (x << 1) ^ (fb ? p_polynom : '0);
    end
    return x;
  endfunction

  if (p_PROTECTED) begin : g_tmr
    (* keep = "true", shreg_extract = "no" *) logic [p_width-1:0]        rt [3][p_len];
    (* keep = "true", shreg_extract = "no" *) logic [p_inp_data_len-1:0] dt [3][p_len];
    (* keep = "true" *) logic [p_width-1:0]        vr [p_len];
    (* keep = "true" *) logic [p_inp_data_len-1:0] vd [p_len];
    // bitwise 2-of-3 vote of every stage; the voted value feeds all copies of the next stage
    always_comb
      for (int i = 0; i < p_len; i++) begin
        vr[i] = (rt[0][i] & rt[1][i]) | (rt[0][i] & rt[2][i]) | (rt[1][i] & rt[2][i]);
        vd[i] = (dt[0][i] & dt[1][i]) | (dt[0][i] & dt[2][i]) | (dt[1][i] & dt[2][i]);
      end
    // three copies load from the voted previous stage, so an upset copy is scrubbed next edge
    always_ff @(posedge clk)
      for (int k = 0; k < 3; k++)
        if (rstN) begin
          for (int i = 0; i < p_len; i++) begin
            rt[k][i] <= '0;
            dt[k][i] <= '0;
          end
        end else begin
          dt[k][0] <= inp_data;
          rt[k][0] <= crc_update('0, inp_data);
          for (int i = 1; i < p_len; i++) begin
            dt[k][i] <= vd[i-1];
            rt[k][i] <= crc_update(vr[i-1], vd[i-1]);
          end
        end
    assign outp_data = vr[p_len-1];
  end else if (p_FPGA_CELL_big) begin : g_keep
    (* keep = "true", shreg_extract = "no" *) logic [p_width-1:0]        r [p_len];
    (* keep = "true", shreg_extract = "no" *) logic [p_inp_data_len-1:0] d [p_len];
    // plain chain, each stage folds its delayed copy of the word into the running CRC
    always_ff @(posedge clk)
      if (rstN) begin
        for (int i = 0; i < p_len; i++) begin
          r[i] <= '0;
          d[i] <= '0;
        end
      end else begin
        d[0] <= inp_data;
        r[0] <= crc_update('0, inp_data);
        for (int i = 1; i < p_len; i++) begin
          d[i] <= d[i-1];
          r[i] <= crc_update(r[i-1], d[i-1]);
        end
      end
    assign outp_data = r[p_len-1];
  end else begin : g_srl
    logic [p_width-1:0]        r [p_len];
    logic [p_inp_data_len-1:0] d [p_len];
    // plain chain without placement attributes, so the word delay line may map to shift-register cells
    always_ff @(posedge clk)
      if (rstN) begin
        for (int i = 0; i < p_len; i++) begin
          r[i] <= '0;
          d[i] <= '0;
        end
      end else begin
        d[0] <= inp_data;
        r[0] <= crc_update('0, inp_data);
        for (int i = 1; i < p_len; i++) begin
          d[i] <= d[i-1];
          r[i] <= crc_update(r[i-1], d[i-1]);
        end
      end
    assign outp_data = r[p_len-1];
  end
endmodule

// File: tb/tb_crc_hash_pipeline.sv
// tb_crc_hash_pipeline: table/scoreboard bench for the CRC hash pipeline, plain and TMR variants
module tb_crc_hash_pipeline;
  logic clk = 0, rst = 1;
  logic [7:0] in_a = 8'h30, in_x = 8'h31;
  logic [7:0] o128p, o128t, o1, o2, o4, o4t;
  logic [15:0] o16;
  int errors = 0, checks = 0;

  typedef struct {logic [7:0] w; logic [7:0] e;} vec_t;
  vec_t vec [12];
  logic [7:0] q [$];
  logic [7:0] h128;

  always #5 clk = ~clk;

  crc_hash_pipeline #(.p_len(128)) u128p (.clk(clk), .rstN(rst), .inp_data(in_a), .outp_data(o128p));
  crc_hash_pipeline #(.p_len(128), .p_PROTECTED(1)) u128t (.clk(clk), .rstN(rst), .inp_data(in_a), .outp_data(o128t));
  crc_hash_pipeline #(.p_len(1), .p_FPGA_CELL_big(0)) u1 (.clk(clk), .rstN(rst), .inp_data(in_a), .outp_data(o1));
  crc_hash_pipeline #(.p_len(2)) u2 (.clk(clk), .rstN(rst), .inp_data(in_a), .outp_data(o2));
  crc_hash_pipeline #(.p_len(4), .p_FPGA_CELL_big(0)) u4 (.clk(clk), .rstN(rst), .inp_data(in_a), .outp_data(o4));
  crc_hash_pipeline #(.p_len(4), .p_PROTECTED(1)) u4t (.clk(clk), .rstN(rst), .inp_data(in_a), .outp_data(o4t));
  crc_hash_pipeline #(.p_len(1), .p_width(16), .p_polynom(16'h1021), .p_inp_data_len(8)) u16 (.clk(clk), .rstN(rst), .inp_data(in_x), .outp_data(o16));

  // byte-at-a-time reference CRC (XOR word into top byte, then shift 8)
  function automatic logic [15:0] mdl(input logic [15:0] c, input logic [7:0] w, input int wid, input logic [15:0] poly);
    logic [15:0] msb, mask, x;
    msb = 16'(1) << (wid - 1);
    mask = wid == 16 ? 16'hFFFF : (16'(1) << wid) - 16'(1);
    x = c ^ (16'(w) << (wid - 8));
    repeat (8) x = (x & msb) != 0 ? (x << 1) ^ poly : x << 1;
    return x & mask;
  endfunction

  function automatic logic [7:0] rep8(input logic [7:0] w, input int n);
    logic [15:0] c = 0;
    repeat (n) c = mdl(c, w, 8, 16'h0031);
    return c[7:0];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reset_pulse();
    rst = 1;
    in_a = 8'hA7;
    @(negedge clk);
    chk("rst_u128p", 16'(o128p), 0);
    chk("rst_u128t", 16'(o128t), 0);
    chk("rst_u1", 16'(o1), 0);
    chk("rst_u2", 16'(o2), 0);
    chk("rst_u4", 16'(o4), 0);
    chk("rst_u4t", 16'(o4t), 0);
    rst = 0;
  endtask

  task automatic run_stream();
    logic [7:0] e;
    q.delete();
    repeat (3) q.push_back(8'h00);
    for (int k = 0; k < 12; k++) begin
      in_a = vec[k].w;
      q.push_back(vec[k].e);
      @(negedge clk);
      e = q.pop_front();
      chk("stream_u4", 16'(o4), 16'(e));
      chk("stream_u4t", 16'(o4t), 16'(e));
      if (k == 5) u4t.g_tmr.rt[1][1] = u4t.g_tmr.rt[1][1] ^ 8'h08;
      if (k == 7) u4t.g_tmr.dt[1][2] = u4t.g_tmr.dt[1][2] ^ 8'h40;
      if (k == 9) u4t.g_tmr.rt[0][3] = u4t.g_tmr.rt[0][3] ^ 8'h80;
      if (k == 5 || k == 7 || k == 9) begin
        #1;
        chk("upset_u4t", 16'(o4t), 16'(e));
      end
    end
  endtask

  initial begin
    vec[0].w = 8'h30; vec[1].w = 8'h00; vec[2].w = 8'hFF; vec[3].w = 8'hA5;
    vec[4].w = 8'h5A; vec[5].w = 8'h01; vec[6].w = 8'h80; vec[7].w = 8'h7E;
    vec[8].w = 8'h30; vec[9].w = 8'h30; vec[10].w = 8'hC3; vec[11].w = 8'h3C;
    for (int k = 0; k < 12; k++) vec[k].e = rep8(vec[k].w, 4);
    h128 = rep8(8'h30, 128);
    repeat (10) @(negedge clk);
    chk("init_u128p", 16'(o128p), 0);
    chk("init_u128t", 16'(o128t), 0);
    chk("init_u1", 16'(o1), 0);
    chk("init_u2", 16'(o2), 0);
    chk("init_u4", 16'(o4), 0);
    chk("init_u16", o16, 0);
    rst = 0;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      chk("fill_u128p", 16'(o128p), c < 128 ? 16'h0 : 16'(h128));
      chk("fill_u128t", 16'(o128t), c < 128 ? 16'h0 : 16'(h128));
      chk("len1", 16'(o1), 16'h00C5);
      chk("len2", 16'(o2), c < 2 ? 16'h0 : 16'h0077);
      chk("xmodem", o16, 16'h2672);
      if (c == 130) begin
        u128t.g_tmr.rt[1][60] = u128t.g_tmr.rt[1][60] ^ 8'h01;
        u128t.g_tmr.dt[2][100] = u128t.g_tmr.dt[2][100] ^ 8'h10;
        u128t.g_tmr.rt[0][127] = u128t.g_tmr.rt[0][127] ^ 8'h20;
        #1;
        chk("upset_u128t", 16'(o128t), 16'(h128));
      end
    end
    in_a = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("zero_len1", 16'(o1), 0);
    end
    reset_pulse();
    run_stream();
    reset_pulse();
    run_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
